bcd_counter_mod_04: RTL and testbench

- Parametrised N-digit BCD modulo counter for the clock datapath. Generalises the fixed 00–23 hour counter to any digit count and any BCD terminal value, e.g. 59 for min/sec, 23 for hours, 99 for free-running.
- Adds count enable, up/down direction, synchronous preset load with validity check, and registered carry and borrow pulses.
- Instances chain through cout_04/bout_04 into the next stage's en_04.

---
 rtl/bcd_counter_mod_04.sv | 137 +++++++++++++
 tb/tb_bcd_counter_mod_04.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_mod_04.sv
// Purpose: N-digit packed-BCD modulo counter (0..MAX_BCD) with enable, up/down, preset load and wrap pulses.
// Latency: 1 clk from edge to dout_04/cout_04/bout_04/err_04; tc_04 is combinational (0 clk).
// Backpressure: none; en_04 is a plain step enable, chained stages use cout_04/bout_04 or tc_04 as next en_04.
module bcd_counter_mod_04 #(
    parameter int                    DIGITS  = 2,
    parameter logic [4*DIGITS-1:0]   MAX_BCD = 'h23
) (
    input  logic                   clk_04,
    input  logic                   rst_04,
    input  logic                   en_04,
    input  logic                   up_04,
    input  logic                   load_04,
    input  logic [4*DIGITS-1:0]    din_04,
    output logic [4*DIGITS-1:0]    dout_04,
    output logic                   cout_04,
    output logic                   bout_04,
    output logic                   err_04,
    output logic                   tc_04
);

    localparam int W = 4 * DIGITS;

    // Elaboration-time guards: digit count range and a well-formed BCD terminal value.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter_mod_04: DIGITS must be in 1..8");
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_chk_max
        if (MAX_BCD[4*g +: 4] > 4'd9) begin : g_bad_nibble
            $error("bcd_counter_mod_04: MAX_BCD has a nibble above 9");
        end
    end

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         inc_carry;
    logic         dec_borrow;
    logic         din_is_bcd;
    logic         din_le_max;
    logic         din_decided;
    logic         load_ok;
    logic         at_max;
    logic         at_zero;

    assign at_max  = (dout_04 == MAX_BCD);
    assign at_zero = (dout_04 == '0);

    // Look-ahead terminal count so the next stage can enable in this same cycle.
    assign tc_04 = en_04 & ((up_04 & at_max) | (~up_04 & at_zero));

    // Ripple BCD increment and decrement across all digits in one cycle.
    always_comb begin
        inc_val    = dout_04;
        dec_val    = dout_04;
        inc_carry  = 1'b1;
        dec_borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_carry) begin
                if (dout_04[4*k +: 4] == 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end else begin
                    inc_val[4*k +: 4] = dout_04[4*k +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
            if (dec_borrow) begin
                if (dout_04[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end else begin
                    dec_val[4*k +: 4] = dout_04[4*k +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // Preset check: every nibble must be a decimal digit, and the value must not exceed
    // the terminal value; magnitude is decided by the first differing digit from the top.
    always_comb begin
        din_is_bcd  = 1'b1;
        din_le_max  = 1'b1;
        din_decided = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            if (din_04[4*k +: 4] > 4'd9) begin
                din_is_bcd = 1'b0;
            end
            if (!din_decided) begin
                if (din_04[4*k +: 4] < MAX_BCD[4*k +: 4]) begin
                    din_decided = 1'b1;
                    din_le_max  = 1'b1;
                end else if (din_04[4*k +: 4] > MAX_BCD[4*k +: 4]) begin
                    din_decided = 1'b1;
                    din_le_max  = 1'b0;
                end
            end
        end
        load_ok = din_is_bcd & din_le_max;
    end

    // Count state and single-cycle pulses; priority is reset, load, count, hold.
    always_ff @(posedge clk_04) begin
        if (rst_04) begin
            dout_04 <= '0;
            cout_04 <= 1'b0;
            bout_04 <= 1'b0;
            err_04  <= 1'b0;
        end else begin
            cout_04 <= 1'b0;
            bout_04 <= 1'b0;
            err_04  <= 1'b0;
            if (load_04) begin
                if (load_ok) begin
                    dout_04 <= din_04;
                end else begin
                    err_04  <= 1'b1;
                end
            end else if (en_04) begin
                if (up_04) begin
                    if (at_max) begin
                        dout_04 <= '0;
                        cout_04 <= 1'b1;
                    end else begin
                        dout_04 <= inc_val;
                    end
                end else begin
                    if (at_zero) begin
                        dout_04 <= MAX_BCD;
                        bout_04 <= 1'b1;
                    end else begin
                        dout_04 <= dec_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_mod_04.sv
// Bench for bcd_counter_mod_04: four instances (00-23, 000-999, 00-59, single digit 0..0)
// share one control stream; integer-arithmetic reference model checks every edge.
module tb_bcd_counter_mod_04;

    logic        clk_04;
    logic        rst_04;
    logic        en_04;
    logic        up_04;
    logic        load_04;
    logic [11:0] din_04;

    logic [7:0]  d2;
    logic [11:0] d3;
    logic [7:0]  d59;
    logic [3:0]  d0;
    logic [3:0]  c_a, b_a, e_a, t_a;

    bcd_counter_mod_04 #(.DIGITS(2), .MAX_BCD(8'h23)) u2 (
        .clk_04(clk_04), .rst_04(rst_04), .en_04(en_04), .up_04(up_04), .load_04(load_04),
        .din_04(din_04[7:0]), .dout_04(d2), .cout_04(c_a[0]), .bout_04(b_a[0]),
        .err_04(e_a[0]), .tc_04(t_a[0]));
    bcd_counter_mod_04 #(.DIGITS(3), .MAX_BCD(12'h999)) u3 (
        .clk_04(clk_04), .rst_04(rst_04), .en_04(en_04), .up_04(up_04), .load_04(load_04),
        .din_04(din_04), .dout_04(d3), .cout_04(c_a[1]), .bout_04(b_a[1]),
        .err_04(e_a[1]), .tc_04(t_a[1]));
    bcd_counter_mod_04 #(.DIGITS(2), .MAX_BCD(8'h59)) u59 (
        .clk_04(clk_04), .rst_04(rst_04), .en_04(en_04), .up_04(up_04), .load_04(load_04),
        .din_04(din_04[7:0]), .dout_04(d59), .cout_04(c_a[2]), .bout_04(b_a[2]),
        .err_04(e_a[2]), .tc_04(t_a[2]));
    bcd_counter_mod_04 #(.DIGITS(1), .MAX_BCD(4'h0)) u0 (
        .clk_04(clk_04), .rst_04(rst_04), .en_04(en_04), .up_04(up_04), .load_04(load_04),
        .din_04(din_04[3:0]), .dout_04(d0), .cout_04(c_a[3]), .bout_04(b_a[3]),
        .err_04(e_a[3]), .tc_04(t_a[3]));

    initial clk_04 = 1'b0;
    always #5 clk_04 = ~clk_04;

    int passes = 0;
    int total  = 0;

    // Reference model: counts held as plain integers, wrap computed modulo (max+1).
    int mmax [4] = '{23, 999, 59, 0};
    int mdig [4] = '{2, 3, 2, 1};
    int mv   [4];
    bit mc   [4];
    bit mb   [4];
    bit me   [4];
    bit mvalid = 1'b0;

    function automatic logic [11:0] dout_of(int i);
        case (i)
            0:       return {4'h0, d2};
            1:       return d3;
            2:       return {4'h0, d59};
            default: return {8'h00, d0};
        endcase
    endfunction

    function automatic int bcd_val(logic [11:0] v, int nd, output bit ok);
        int r;
        r  = 0;
        ok = 1'b1;
        for (int k = nd - 1; k >= 0; k--) begin
            int n;
            n = int'((v >> (4 * k)) & 12'hF);
            if (n > 9) ok = 1'b0;
            r = r * 10 + n;
        end
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(int x);
        logic [11:0] r;
        int          y;
        r = '0;
        y = x;
        for (int k = 0; k < 3; k++) begin
            r = r | (12'((y % 10)) << (4 * k));
            y = y / 10;
        end
        return r;
    endfunction

    task automatic model_step(int i);
        bit ok;
        int v;
        mc[i] = 1'b0;
        mb[i] = 1'b0;
        me[i] = 1'b0;
        if (rst_04) begin
            mv[i] = 0;
        end else if (load_04) begin
            v = bcd_val(din_04, mdig[i], ok);
            if (ok && v <= mmax[i]) mv[i] = v;
            else                    me[i] = 1'b1;
        end else if (en_04) begin
            if (up_04) begin
                if (mv[i] == mmax[i]) begin mv[i] = 0; mc[i] = 1'b1; end
                else                  mv[i] = mv[i] + 1;
            end else begin
                if (mv[i] == 0) begin mv[i] = mmax[i]; mb[i] = 1'b1; end
                else            mv[i] = mv[i] - 1;
            end
        end
    endtask

    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Drive inputs just after an edge, then check tc against the model before the next edge.
    task automatic pre(bit r, bit e, bit u, bit l, logic [11:0] d);
        rst_04  = r;
        en_04   = e;
        up_04   = u;
        load_04 = l;
        din_04  = d;
        #1;
        if (mvalid) begin
            for (int i = 0; i < 4; i++)
                chk($sformatf("model tc[%0d]", i), {11'b0, t_a[i]},
                    {11'b0, en_04 & (up_04 ? (mv[i] == mmax[i]) : (mv[i] == 0))});
        end
    endtask

    // Clock the edge, advance the model, then compare registered outputs.
    task automatic post();
        @(posedge clk_04);
        for (int i = 0; i < 4; i++) model_step(i);
        if (rst_04) mvalid = 1'b1;
        #1;
        if (mvalid) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model dout[%0d]", i), dout_of(i), to_bcd(mv[i]));
                chk($sformatf("model cout[%0d]", i), {11'b0, c_a[i]}, {11'b0, mc[i]});
                chk($sformatf("model bout[%0d]", i), {11'b0, b_a[i]}, {11'b0, mb[i]});
                chk($sformatf("model err[%0d]",  i), {11'b0, e_a[i]}, {11'b0, me[i]});
            end
        end
    endtask

    typedef struct {
        bit         rst, en, up, load;
        logic [7:0] din;
        bit         tc;     // tc_04 before the edge
        logic [7:0] dout;   // after the edge
        bit         c, b, e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(bit r, bit e, bit u, bit l, logic [7:0] d, bit tc,
                       logic [7:0] q, bit c, bit b, bit er);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.load = l; v.din = d;
        v.tc = tc; v.dout = q; v.c = c; v.b = b; v.e = er;
        vecs.push_back(v);
    endtask

    task automatic hand(bit r, bit e, bit u, bit l, logic [11:0] d, string nm,
                        logic [11:0] q, bit c, bit b);
        pre(r, e, u, l, d);
        post();
        chk({nm, " dout"}, (nm[0] == "6") ? {4'h0, d59} : d3, q);
        chk({nm, " cout"}, {11'b0, (nm[0] == "6") ? c_a[2] : c_a[1]}, {11'b0, c});
        chk({nm, " bout"}, {11'b0, (nm[0] == "6") ? b_a[2] : b_a[1]}, {11'b0, b});
    endtask

    initial begin
        logic [7:0] seq5 [7];
        rst_04 = 1'b0; en_04 = 1'b0; up_04 = 1'b1; load_04 = 1'b0; din_04 = '0;
        @(negedge clk_04);

        // 1: reset, then 24 up steps through 23 back to 00
        add(1, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 24; i++)
            add(0, 1, 1, 0, 8'h00, i == 23, 8'((((i + 1) % 24) / 10) * 16 + ((i + 1) % 24) % 10),
                i == 23, 0, 0);
        // 2: load 05 and count down across the zero wrap
        add(0, 0, 1, 1, 8'h05, 0, 8'h05, 0, 0, 0);
        seq5 = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h23};
        for (int i = 0; i < 7; i++)
            add(0, 1, 0, 0, 8'h00, seq5[i] == 8'h00,
                (i == 6) ? 8'h22 : ((i == 5) ? 8'h23 : seq5[i + 1]), 0, i == 5, 0);
        // 3: rejected loads pulse err and hold the count; valid load of the max
        add(0, 0, 1, 1, 8'h1A, 0, 8'h22, 0, 0, 1);
        add(0, 0, 1, 0, 8'h00, 0, 8'h22, 0, 0, 0);
        add(0, 0, 1, 1, 8'h24, 0, 8'h22, 0, 0, 1);
        add(0, 0, 1, 0, 8'h00, 0, 8'h22, 0, 0, 0);
        add(0, 0, 1, 1, 8'h30, 0, 8'h22, 0, 0, 1);
        add(0, 0, 1, 1, 8'h23, 0, 8'h23, 0, 0, 0);
        // 4: load wins over a wrapping count; reset wins over load mid-count
        add(0, 1, 1, 1, 8'h10, 1, 8'h10, 0, 0, 0);
        add(0, 1, 1, 0, 8'h00, 0, 8'h11, 0, 0, 0);
        add(0, 1, 1, 0, 8'h00, 0, 8'h12, 0, 0, 0);
        add(1, 1, 1, 1, 8'h05, 0, 8'h00, 0, 0, 0);
        add(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0);

        foreach (vecs[n]) begin
            pre(vecs[n].rst, vecs[n].en, vecs[n].up, vecs[n].load, {4'h0, vecs[n].din});
            chk($sformatf("vec%0d tc", n), {11'b0, t_a[0]}, {11'b0, vecs[n].tc});
            post();
            chk($sformatf("vec%0d dout", n), {4'h0, d2}, {4'h0, vecs[n].dout});
            chk($sformatf("vec%0d cout", n), {11'b0, c_a[0]}, {11'b0, vecs[n].c});
            chk($sformatf("vec%0d bout", n), {11'b0, b_a[0]}, {11'b0, vecs[n].b});
            chk($sformatf("vec%0d err",  n), {11'b0, e_a[0]}, {11'b0, vecs[n].e});
        end

        // 5: three-digit ripple carry/borrow and full wrap
        hand(0, 0, 1, 1, 12'h099, "5 load099", 12'h099, 0, 0);
        hand(0, 1, 1, 0, 12'h000, "5 up",      12'h100, 0, 0);
        hand(0, 0, 1, 1, 12'h100, "5 load100", 12'h100, 0, 0);
        hand(0, 1, 0, 0, 12'h000, "5 down",    12'h099, 0, 0);
        hand(0, 0, 1, 1, 12'h999, "5 load999", 12'h999, 0, 0);
        hand(0, 1, 1, 0, 12'h000, "5 wrap",    12'h000, 1, 0);

        // 6: gated enable with direction flip on the 00-59 instance
        hand(0, 0, 1, 1, 12'h012, "6 load12", 12'h012, 0, 0);
        hand(0, 0, 1, 0, 12'h000, "6 hold a", 12'h012, 0, 0);
        hand(0, 1, 1, 0, 12'h000, "6 up",     12'h013, 0, 0);
        hand(0, 0, 0, 0, 12'h000, "6 hold b", 12'h013, 0, 0);
        hand(0, 1, 0, 0, 12'h000, "6 down",   12'h012, 0, 0);
        hand(0, 0, 0, 0, 12'h000, "6 hold c", 12'h012, 0, 0);

        // Randomized stream against the model on all four instances
        for (int n = 0; n < 400; n++) begin
            logic [11:0] d;
            if ($urandom_range(0, 1) == 0)
                d = 12'($urandom_range(0, 4095));
            else
                d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            pre($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 5) == 0, d);
            post();
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
